sig_monitor: RTL and testbench
==============================

# sig_monitor

Synthesizable test-harness monitor that snoops the core's data-memory write bus. It captures a parametrised signature window into a private buffer with per-word written flags. It detects the riscv-tests style `tohost` completion write and enforces a cycle timeout. It replaces fixed-length runs and fixed 8-word signature dumps in core benches, and can sit beside any core generation (single-cycle or pipelined) on the dmem write port.

## Interface
- `SIG_BASE`, 32'h0000_1000: byte address of signature word 0; must be word aligned.
- `SIG_WORDS`, 8: number of 32-bit signature words captured; 1..256.
- `TOHOST_ADDR`, 32'h0000_2000: byte address of the completion register; word aligned, outside the signature window.
- `TIMEOUT_CYCLES`, 2000: run-cycle limit; 0 disables the timeout.
- `IDX_W`, $clog2(SIG_WORDS) (min 1): width of the readout index.
- `clk`, in, 1: single clock, all state on rising edge.
- `rst_n`, in, 1: reset is asynchronous and active-low.
- `en`, in, 1: run-cycle counting enable; writes are snooped regardless.
- `dmem_we`, in, 1: data-memory write strobe.
- `dmem_addr`, in, 32: byte address; bits [1:0] ignored.
- `dmem_wdata`, in, 32: write data, little-endian lanes.
- `dmem_be`, in, 4: byte enables; lane k is `wdata[8k+7:8k]`.
- `rd_idx`, in, IDX_W: signature readout index.
- `rd_data`, out, 32: signature word `rd_idx`, registered.
- `rd_written`, out, 1: word `rd_idx` has had at least one enabled byte written, registered.
- `done`, out, 1: run finished (pass, fail or timeout).
- `pass`, out, 1: `tohost` == 1 received.
- `timeout`, out, 1: cycle limit reached before completion.
- `fail_code`, out, 32: `{1'b0, tohost[31:1]}` of a failing completion write, else 0.
- `cycle_cnt`, out, 32: enabled run cycles elapsed, saturating at 32'hFFFF_FFFF.

## Operation
- States: RUN, PASS, FAIL, TMO. Reset enters RUN. PASS, FAIL and TMO are terminal until reset.
- Signature hit: `dmem_we` & state==RUN & `dmem_addr[31:2]` in [SIG_BASE>>2, (SIG_BASE>>2)+SIG_WORDS). Index = `dmem_addr[31:2]` − (SIG_BASE>>2), computed at 30-bit width and then truncated to IDX_W. Each lane with `be[k]`=1 is written; lanes with `be[k]`=0 keep their value. `written[idx]` is set if any `be` bit is 1.
- Tohost hit: `dmem_we` & RUN & `dmem_addr[31:2]==TOHOST_ADDR>>2` & `be`==4'hF. Partial-`be` writes to tohost are ignored.
  - Data == 1 → PASS.
  - Data[0]==1 and data≠1 → FAIL, `fail_code` latched.
  - Data[0]==0 → ignored, no state change.
- Timeout: in RUN with `en`=1, `cycle_cnt` increments. When TIMEOUT_CYCLES≠0 and the incremented value equals TIMEOUT_CYCLES, the state moves to TMO.
- Same-edge tohost completion and timeout: tohost wins (PASS/FAIL, `timeout`=0).
- In terminal states, signature, `written`, `cycle_cnt` and `fail_code` are frozen. Later writes are ignored.
- Buffer contents are not reset; `written` flags are. `rd_data` for an unwritten word is don't-care; benches must check `rd_written`.
- `rd_idx` ≥ SIG_WORDS → `rd_data`=0, `rd_written`=0.

## Timing
- Reset values: `done`=0, `pass`=0, `timeout`=0, `fail_code`=0, `cycle_cnt`=0, `rd_data`=0, `rd_written`=0, all `written` flags 0, state RUN.
- Signature write lands on the edge where `dmem_we`=1.
- Readout latency is 1 cycle: `rd_data`/`rd_written` reflect `rd_idx` and the buffer as of the previous edge. Reading a word written on edge N returns the new value after edge N+1.
- `done`/`pass`/`timeout`/`fail_code` are registered outputs decoded from state. They go high after the edge that accepts the tohost write or reaches the limit, and stay high until reset.
- `cycle_cnt` after edge N equals the number of preceding RUN edges with `en`=1.
- Asynchronous reset mid-run clears state immediately; the run restarts from 0 on the first edge after release.

## Test plan
- Writes of 0x11111111·(i+1) to 0x1000+4i for i=0..7, then tohost=1 → `pass`=1, `done`=1. Each `rd_idx`=i gives that value with `rd_written`=1 one cycle later.
- Word 0 = 0xAABBCCDD, then `be`=4'b0010 with wdata 0x0000EE00 → `rd_data`=0xAABBEEDD. Word 3 never written → `rd_written`=0.
- tohost=2 (ignored), then tohost=0x0000_000B → `done`=1, `pass`=0, `fail_code`=5.
- TIMEOUT_CYCLES=20, `en`=1, no tohost → `timeout`=1 after the 20th edge and `cycle_cnt`=20. A subsequent tohost=1 leaves `pass`=0.
- tohost=1 written on the exact edge the count reaches TIMEOUT_CYCLES → `pass`=1, `timeout`=0.
- Write to 0x1020 (SIG_WORDS=8) and partial-`be` write of 1 to tohost → no buffer change, no completion. Assert `rst_n` mid-run → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sig_monitor.sv
// sig_monitor: snoops the dmem write bus, captures a signature window and detects tohost completion or timeout
module sig_monitor #(
  parameter logic [31:0] SIG_BASE       = 32'h0000_1000,
  parameter int unsigned SIG_WORDS      = 8,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_2000,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned IDX_W          = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dmem_we,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic [3:0]       dmem_be,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  output logic             rd_written,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [31:0]      fail_code,
  output logic [31:0]      cycle_cnt
);
  typedef enum logic [1:0] {RUN, PASS, FAIL, TMO} state_e;
  state_e               state_q, state_d;
  logic [31:0]          buf_q [SIG_WORDS];
  logic [SIG_WORDS-1:0] written_q, written_d;
  logic [31:0]          cycle_q, cycle_d, cycle_inc;
  logic [31:0]          fail_q, fail_d;
  logic [31:0]          rd_data_q;
  logic                 rd_written_q;
  logic                 run, sig_hit, tohost_hit, rd_ok;
  logic [29:0]          word, off;
  logic [IDX_W-1:0]     idx;
  logic                 unused_addr_lsb;
  assign unused_addr_lsb = ^dmem_addr[1:0];
  assign run        = state_q == RUN;
  assign word       = dmem_addr[31:2];
  assign off        = word - SIG_BASE[31:2];
  assign idx        = off[IDX_W-1:0];
  assign sig_hit    = dmem_we && run && word >= SIG_BASE[31:2] && off < 30'(SIG_WORDS);
  assign tohost_hit = dmem_we && run && word == TOHOST_ADDR[31:2] && dmem_be == 4'hF;
  assign cycle_inc  = &cycle_q ? cycle_q : cycle_q + 32'd1;
  assign rd_ok      = 32'(rd_idx) < SIG_WORDS;
  // Next state: completion beats timeout on the same edge; everything freezes once out of RUN
  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    fail_d    = fail_q;
    written_d = written_q;
    if (run) begin
      if (en) cycle_d = cycle_inc;
      if (sig_hit && |dmem_be) written_d[idx] = 1'b1;
      if (tohost_hit && dmem_wdata == 32'd1) state_d = PASS;
      else if (tohost_hit && dmem_wdata[0]) begin
        state_d = FAIL;
        fail_d  = {1'b0, dmem_wdata[31:1]};
      end else if (TIMEOUT_CYCLES != 0 && en && cycle_inc == TIMEOUT_CYCLES) state_d = TMO;
    end
  end
  // Control state, counters, written flags and registered readout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cycle_q      <= '0;
      fail_q       <= '0;
      written_q    <= '0;
      rd_data_q    <= '0;
      rd_written_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      fail_q       <= fail_d;
      written_q    <= written_d;
      rd_data_q    <= rd_ok ? buf_q[rd_idx] : '0;
      rd_written_q <= rd_ok && written_q[rd_idx];
    end
  end
  // Signature storage is not reset; per-lane byte-enable merge
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (sig_hit && dmem_be[k]) buf_q[idx][8*k +: 8] <= dmem_wdata[8*k +: 8];
  end
  assign done       = !run;
  assign pass       = state_q == PASS;
  assign timeout    = state_q == TMO;
  assign fail_code  = fail_q;
  assign cycle_cnt  = cycle_q;
  assign rd_data    = rd_data_q;
  assign rd_written = rd_written_q;
endmodule

// File: tb/tb_sig_monitor.sv
// tb_sig_monitor: directed and randomized checks of sig_monitor against a behavioural run model
module tb_sig_monitor;
  logic        clk = 0, rst_n = 1, en = 0, dmem_we = 0;
  logic [31:0] dmem_addr = 0, dmem_wdata = 0;
  logic [3:0]  dmem_be = 0;
  logic [2:0]  rd_idx = 0;
  logic [31:0] rd_data, fail_code, cycle_cnt;
  logic        rd_written, done, pass, timeout;
  int vecs = 0, errs = 0;
  logic [31:0] m_buf [8];
  bit          m_wr [8];
  int          m_cnt;
  bit          m_done, m_pass, m_tmo, e_rw;
  logic [31:0] m_fail, e_rd;

  sig_monitor #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_written(rd_written), .done(done), .pass(pass), .timeout(timeout),
    .fail_code(fail_code), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_wr[i] = 0;
    m_cnt = 0; m_done = 0; m_pass = 0; m_tmo = 0; m_fail = 0; e_rw = 0;
  endtask

  // one clock: drive inputs, advance the model, return 1ns after the edge
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic e, input logic [2:0] ri);
    int w;
    dmem_we = we; dmem_addr = a; dmem_wdata = d; dmem_be = b; en = e; rd_idx = ri;
    e_rw = m_wr[ri]; e_rd = m_buf[ri];
    if (!m_done) begin
      if (we && a >= 32'h1000 && a < 32'h1020) begin
        w = int'((a - 32'h1000) >> 2);
        for (int k = 0; k < 4; k++) if (b[k]) m_buf[w][8*k +: 8] = d[8*k +: 8];
        if (b != 0) m_wr[w] = 1;
      end
      if (e) m_cnt++;
      if (we && (a & ~32'h3) == 32'h2000 && b == 4'hF && d[0]) begin
        m_done = 1; m_pass = (d == 1); m_fail = (d == 1) ? 0 : d >> 1;
      end else if (e && m_cnt == 20) begin
        m_done = 1; m_tmo = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    dmem_we = 0; en = 0;
    #2 rst_n = 0;
    m_reset();
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    m_reset();
    #2;
    vecs++;
    if ({done, pass, timeout, fail_code, cycle_cnt, rd_data, rd_written} !== '0) begin
      errs++;
      $display("FAIL reset_vals: done=%b pass=%b tmo=%b fail=%h cnt=%0d rd=%h rw=%b required all 0",
               done, pass, timeout, fail_code, cycle_cnt, rd_data, rd_written);
    end
    #4 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_signature();
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 32'h1000 + 4*i, 32'h11111111 * (i + 1), 4'hF, 0, 0);
    cyc(1, 32'h2000, 1, 4'hF, 0, 0);
    vecs++;
    if (done !== 1 || pass !== 1 || timeout !== 0) begin
      errs++; $display("FAIL sig_pass: done=%b pass=%b tmo=%b required 1 1 0", done, pass, timeout);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 3'(i));
      vecs++;
      if (rd_data !== 32'h11111111 * (i + 1) || rd_written !== 1) begin
        errs++; $display("FAIL sig_read[%0d]: got %h/%b required %h/1", i, rd_data, rd_written, 32'h11111111 * (i + 1));
      end
    end
  endtask

  task automatic test_partial();
    do_reset();
    cyc(1, 32'h1000, 32'hAABBCCDD, 4'hF, 0, 0);
    cyc(1, 32'h1000, 32'h0000EE00, 4'b0010, 0, 0);
    cyc(1, 32'h1020, 32'hDEADBEEF, 4'hF, 0, 0);
    cyc(1, 32'h1014, 32'h12345678, 4'h0, 0, 0);
    cyc(1, 32'h2000, 1, 4'b0111, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    vecs++;
    if (rd_data !== 32'hAABBEEDD || rd_written !== 1) begin
      errs++; $display("FAIL partial_be: got %h/%b required aabbeedd/1", rd_data, rd_written);
    end
    cyc(0, 0, 0, 0, 0, 3);
    vecs++;
    if (rd_written !== 0) begin errs++; $display("FAIL unwritten_w3: rd_written=%b required 0", rd_written); end
    cyc(0, 0, 0, 0, 0, 5);
    vecs++;
    if (rd_written !== 0) begin errs++; $display("FAIL be0_w5: rd_written=%b required 0", rd_written); end
    vecs++;
    if (done !== 0 || pass !== 0) begin
      errs++; $display("FAIL partial_tohost: done=%b pass=%b required 0 0", done, pass);
    end
  endtask

  task automatic test_fail();
    do_reset();
    cyc(1, 32'h2000, 2, 4'hF, 0, 0);
    vecs++;
    if (done !== 0) begin errs++; $display("FAIL tohost_even: done=%b required 0", done); end
    cyc(1, 32'h2000, 32'hB, 4'hF, 0, 0);
    vecs++;
    if (done !== 1 || pass !== 0 || timeout !== 0 || fail_code !== 5) begin
      errs++; $display("FAIL fail_code: done=%b pass=%b tmo=%b code=%0d required 1 0 0 5", done, pass, timeout, fail_code);
    end
    cyc(1, 32'h1008, 32'h123, 4'hF, 1, 2);
    cyc(1, 32'h2000, 1, 4'hF, 1, 2);
    vecs++;
    if (rd_written !== 0 || cycle_cnt !== 0 || pass !== 0 || fail_code !== 5) begin
      errs++; $display("FAIL fail_frozen: rw=%b cnt=%0d pass=%b code=%0d required 0 0 0 5", rd_written, cycle_cnt, pass, fail_code);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (19) cyc(0, 0, 0, 0, 1, 0);
    vecs++;
    if (timeout !== 0 || cycle_cnt !== 19) begin
      errs++; $display("FAIL tmo_early: tmo=%b cnt=%0d required 0 19", timeout, cycle_cnt);
    end
    cyc(0, 0, 0, 0, 1, 0);
    vecs++;
    if (timeout !== 1 || done !== 1 || pass !== 0 || cycle_cnt !== 20) begin
      errs++; $display("FAIL tmo_hit: tmo=%b done=%b pass=%b cnt=%0d required 1 1 0 20", timeout, done, pass, cycle_cnt);
    end
    cyc(1, 32'h2000, 1, 4'hF, 1, 0);
    vecs++;
    if (pass !== 0 || timeout !== 1 || cycle_cnt !== 20) begin
      errs++; $display("FAIL tmo_frozen: pass=%b tmo=%b cnt=%0d required 0 1 20", pass, timeout, cycle_cnt);
    end
  endtask

  task automatic test_race();
    do_reset();
    repeat (19) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h2000, 1, 4'hF, 1, 0);
    vecs++;
    if (pass !== 1 || timeout !== 0 || done !== 1 || cycle_cnt !== 20) begin
      errs++; $display("FAIL race: pass=%b tmo=%b done=%b cnt=%0d required 1 0 1 20", pass, timeout, done, cycle_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 32'h1004, 32'h55, 4'hF, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    vecs++;
    if (cycle_cnt !== 4 || rd_written !== 1) begin
      errs++; $display("FAIL pre_reset: cnt=%0d rw=%b required 4 1", cycle_cnt, rd_written);
    end
    #3 rst_n = 0;
    m_reset();
    #1;
    vecs++;
    if ({done, pass, timeout, fail_code, cycle_cnt, rd_data, rd_written} !== '0) begin
      errs++; $display("FAIL async_reset: cnt=%0d rd=%h rw=%b done=%b required all 0", cycle_cnt, rd_data, rd_written, done);
    end
    #2 rst_n = 1;
    cyc(0, 0, 0, 0, 1, 1);
    vecs++;
    if (cycle_cnt !== 1 || rd_written !== 0) begin
      errs++; $display("FAIL restart: cnt=%0d rw=%b required 1 0", cycle_cnt, rd_written);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  b;
    for (int run = 0; run < 8; run++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        d = $urandom;
        case ($urandom_range(0, 15))
          0, 1, 2, 3, 4, 5, 6, 7, 8, 9: a = 32'h1000 + $urandom_range(0, 31);
          10: a = 32'h1020 + $urandom_range(0, 3);
          11: a = 32'h0FFC;
          12: a = $urandom;
          13: begin a = 32'h2000; d[0] = 1'b0; end
          14: a = 32'h2000 + $urandom_range(0, 3);
          default: begin a = 32'h2000; d = 1; end
        endcase
        b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        cyc($urandom_range(0, 4) != 0, a, d, b, $urandom_range(0, 3) != 0, 3'($urandom));
        vecs++;
        if (done !== m_done || pass !== m_pass || timeout !== m_tmo || fail_code !== m_fail ||
            cycle_cnt !== 32'(m_cnt) || rd_written !== e_rw || (e_rw && rd_data !== e_rd)) begin
          errs++;
          $display("FAIL rand[%0d.%0d]: d/p/t=%b%b%b code=%h cnt=%0d rw=%b rd=%h required %b%b%b %h %0d %b %h",
                   run, c, done, pass, timeout, fail_code, cycle_cnt, rd_written, rd_data,
                   m_done, m_pass, m_tmo, m_fail, m_cnt, e_rw, e_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_signature();
    test_partial();
    test_fail();
    test_timeout();
    test_race();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
